psd_stream_pktbuf: RTL and testbench

//  Store-and-forward packet buffer between the PSD custom block's streaming output (fifo_data/tvalid/tlast)
//  and the downstream AXI-Stream DMA. The producer firmware does not wait on backpressure, so words arriving

---
 rtl/psd_stream_pktbuf.sv | 128 ++++++++++++
 tb/tb_psd_stream_pktbuf.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/psd_stream_pktbuf.sv
// Store-and-forward packet buffer: words are written as they arrive, but only
// become visible downstream once the packet's tlast word has been accepted.
// A word lost to a full buffer discards the whole partial packet.
module psd_stream_pktbuf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DROP_W = 8
) (
  input  logic              mclk,
  input  logic              mrst,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic [ADDR_W:0]   pkt_count,
  output logic [DROP_W-1:0] drop_count,
  output logic              overflow,
  input  logic              clr_stats
);

  localparam int unsigned      DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]  FULL_LVL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]  PTR_ONE  = (ADDR_W + 1)'(1);
  localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;

  wstate_t         state, state_nxt;
  logic [DATA_W:0] mem [DEPTH];
  logic [ADDR_W:0] wr_ptr, wr_commit, rd_ptr, fill;
  logic            do_write, do_commit, do_drop, rd_fire;

  // Occupancy counts uncommitted words so a partial packet holds its slots.
  assign fill     = wr_ptr - rd_ptr;
  assign s_tready = (fill != FULL_LVL);

  assign m_tvalid           = (rd_ptr != wr_commit);
  assign {m_tlast, m_tdata} = mem[rd_ptr[ADDR_W-1:0]];
  assign rd_fire            = m_tvalid & m_tready;

  // Write-side state register
  always_ff @(posedge mclk) begin
    if (mrst) state <= W_IDLE;
    else      state <= state_nxt;
  end

  // Write-side next state and write/commit/drop decisions
  always_comb begin
    state_nxt = state;
    do_write  = 1'b0;
    do_commit = 1'b0;
    do_drop   = 1'b0;
    case (state)
      W_IDLE, W_FILL: begin
        if (s_tvalid) begin
          if (s_tready) begin
            do_write = 1'b1;
            if (s_tlast) begin
              do_commit = 1'b1;
              state_nxt = W_IDLE;
            end else begin
              state_nxt = W_FILL;
            end
          end else begin
            do_drop   = 1'b1;
            state_nxt = s_tlast ? W_IDLE : W_DROP;
          end
        end
      end
      W_DROP: begin
        if (s_tvalid && s_tlast) state_nxt = W_IDLE;
      end
      default: state_nxt = W_IDLE;
    endcase
  end

  // Packet storage; contents need no reset since visibility is pointer-gated
  always_ff @(posedge mclk) begin
    if (do_write) mem[wr_ptr[ADDR_W-1:0]] <= {s_tlast, s_tdata};
  end

  // Write, commit and read pointers
  always_ff @(posedge mclk) begin
    if (mrst) begin
      wr_ptr    <= '0;
      wr_commit <= '0;
      rd_ptr    <= '0;
    end else begin
      if (do_drop)       wr_ptr <= wr_commit;
      else if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_commit) wr_commit <= wr_ptr + PTR_ONE;
      if (rd_fire)   rd_ptr    <= rd_ptr + PTR_ONE;
    end
  end

  // Count of complete packets held
  always_ff @(posedge mclk) begin
    if (mrst) begin
      pkt_count <= '0;
    end else begin
      case ({do_commit, rd_fire & m_tlast})
        2'b10:   pkt_count <= pkt_count + PTR_ONE;
        2'b01:   pkt_count <= pkt_count - PTR_ONE;
        default: pkt_count <= pkt_count;
      endcase
    end
  end

  // Drop statistics; a drop in the same cycle as a clear wins and counts as 1
  always_ff @(posedge mclk) begin
    if (mrst) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (do_drop) begin
      overflow <= 1'b1;
      if (clr_stats)              drop_count <= DROP_ONE;
      else if (drop_count != '1)  drop_count <= drop_count + DROP_ONE;
    end else if (clr_stats) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_psd_stream_pktbuf.sv
// Directed bench for psd_stream_pktbuf at DEPTH 8.
module tb_psd_stream_pktbuf;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int DROP_W = 8;

  logic              mclk = 1'b0;
  logic              mrst = 1'b1;
  logic [DATA_W-1:0] s_tdata = '0;
  logic              s_tvalid = 1'b0;
  logic              s_tlast = 1'b0;
  logic              s_tready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready = 1'b0;
  logic [ADDR_W:0]   pkt_count;
  logic [DROP_W-1:0] drop_count;
  logic              overflow;
  logic              clr_stats = 1'b0;

  int checks = 0;
  int passed = 0;

  psd_stream_pktbuf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DROP_W(DROP_W)) dut (
    .mclk(mclk), .mrst(mrst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .pkt_count(pkt_count), .drop_count(drop_count), .overflow(overflow),
    .clr_stats(clr_stats)
  );

  always #5 mclk = ~mclk;

  // Advance one clock; all driving and sampling happens 1ns after the edge.
  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic last);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    step();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    mrst = 1'b1;
    step();
    step();
    mrst = 1'b0;
    checks++; if (s_tready !== 1'b1) $display("FAIL reset_s_tready got %b expected 1", s_tready); else passed++;
    checks++; if (m_tvalid !== 1'b0) $display("FAIL reset_m_tvalid got %b expected 0", m_tvalid); else passed++;
    checks++; if (pkt_count !== 4'd0) $display("FAIL reset_pkt_count got %0d expected 0", pkt_count); else passed++;
    checks++; if (drop_count !== 8'd0) $display("FAIL reset_drop_count got %0d expected 0", drop_count); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b expected 0", overflow); else passed++;
  endtask

  task automatic test_basic();
    logic [31:0] exp_d [3] = '{32'hA1000001, 32'hA1000002, 32'hA1000003};
    m_tready = 1'b1;
    push(exp_d[0], 1'b0);
    push(exp_d[1], 1'b0);
    checks++; if (m_tvalid !== 1'b0) $display("FAIL basic_early_valid got %b expected 0", m_tvalid); else passed++;
    push(exp_d[2], 1'b1);
    checks++; if (pkt_count !== 4'd1) $display("FAIL basic_pkt_count_up got %0d expected 1", pkt_count); else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++; if (m_tvalid !== 1'b1) $display("FAIL basic_valid[%0d] got %b expected 1", i, m_tvalid); else passed++;
      checks++; if (m_tdata !== exp_d[i]) $display("FAIL basic_data[%0d] got %h expected %h", i, m_tdata, exp_d[i]); else passed++;
      checks++; if (m_tlast !== (i == 2)) $display("FAIL basic_last[%0d] got %b expected %b", i, m_tlast, (i == 2)); else passed++;
      step();
    end
    checks++; if (m_tvalid !== 1'b0) $display("FAIL basic_empty got %b expected 0", m_tvalid); else passed++;
    checks++; if (pkt_count !== 4'd0) $display("FAIL basic_pkt_count_down got %0d expected 0", pkt_count); else passed++;
    checks++; if (drop_count !== 8'd0) $display("FAIL basic_drop_count got %0d expected 0", drop_count); else passed++;
  endtask

  task automatic test_hold_until_commit();
    m_tready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      push(32'hB2000000 + 32'(i), (i == 4));
      if (i < 4) begin
        checks++; if (m_tvalid !== 1'b0) $display("FAIL hold_valid_w%0d got %b expected 0", i, m_tvalid); else passed++;
      end
    end
    checks++; if (m_tvalid !== 1'b1) $display("FAIL hold_commit_valid got %b expected 1", m_tvalid); else passed++;
    checks++; if (m_tdata !== 32'hB2000001) $display("FAIL hold_first_word got %h expected B2000001", m_tdata); else passed++;
    m_tready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (m_tdata !== 32'hB2000000 + 32'(i)) $display("FAIL hold_data[%0d] got %h expected %h", i, m_tdata, 32'hB2000000 + 32'(i)); else passed++;
      step();
    end
    checks++; if (m_tvalid !== 1'b0) $display("FAIL hold_empty got %b expected 0", m_tvalid); else passed++;
  endtask

  task automatic test_overflow_drop();
    m_tready = 1'b0;
    for (int i = 1; i <= 6; i++) push(32'hC3000000 + 32'(i), (i == 6));
    push(32'hD4000001, 1'b0);
    push(32'hD4000002, 1'b0);
    checks++; if (s_tready !== 1'b0) $display("FAIL ovf_full_ready got %b expected 0", s_tready); else passed++;
    push(32'hD4000003, 1'b0);
    checks++; if (s_tready !== 1'b1) $display("FAIL ovf_rollback_ready got %b expected 1", s_tready); else passed++;
    checks++; if (drop_count !== 8'd1) $display("FAIL ovf_drop_count got %0d expected 1", drop_count); else passed++;
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_overflow got %b expected 1", overflow); else passed++;
    push(32'hD4000004, 1'b0);
    push(32'hD4000005, 1'b1);
    checks++; if (pkt_count !== 4'd1) $display("FAIL ovf_pkt_count got %0d expected 1", pkt_count); else passed++;
    checks++; if (drop_count !== 8'd1) $display("FAIL ovf_no_second_drop got %0d expected 1", drop_count); else passed++;
    m_tready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      checks++; if (m_tvalid !== 1'b1 || m_tdata !== 32'hC3000000 + 32'(i) || m_tlast !== (i == 6))
        $display("FAIL ovf_out[%0d] got v=%b d=%h l=%b expected v=1 d=%h l=%b", i, m_tvalid, m_tdata, m_tlast, 32'hC3000000 + 32'(i), (i == 6));
      else passed++;
      step();
    end
    checks++; if (m_tvalid !== 1'b0) $display("FAIL ovf_empty got %b expected 0", m_tvalid); else passed++;
  endtask

  task automatic test_long_packet();
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    checks++; if (drop_count !== 8'd0 || overflow !== 1'b0) $display("FAIL long_clear got dc=%0d ov=%b expected dc=0 ov=0", drop_count, overflow); else passed++;
    m_tready = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      push(32'hE0000000 + 32'(i), (i == 12));
      checks++; if (m_tvalid !== 1'b0) $display("FAIL long_leak[%0d] got %b expected 0", i, m_tvalid); else passed++;
    end
    checks++; if (drop_count !== 8'd1) $display("FAIL long_drop_count got %0d expected 1", drop_count); else passed++;
    push(32'hE5000001, 1'b0);
    push(32'hE5000002, 1'b1);
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== 32'hE5000001 || m_tlast !== 1'b0) $display("FAIL long_next_w1 got v=%b d=%h l=%b expected v=1 d=E5000001 l=0", m_tvalid, m_tdata, m_tlast); else passed++;
    step();
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== 32'hE5000002 || m_tlast !== 1'b1) $display("FAIL long_next_w2 got v=%b d=%h l=%b expected v=1 d=E5000002 l=1", m_tvalid, m_tdata, m_tlast); else passed++;
    step();
    checks++; if (m_tvalid !== 1'b0) $display("FAIL long_empty got %b expected 0", m_tvalid); else passed++;
  endtask

  task automatic test_saturation();
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    m_tready = 1'b0;
    for (int i = 1; i <= 8; i++) push(32'hF7000000 + 32'(i), (i == 8));
    checks++; if (s_tready !== 1'b0) $display("FAIL sat_full got %b expected 0", s_tready); else passed++;
    for (int i = 1; i <= 300; i++) begin
      push(32'h5A000000 + 32'(i), 1'b1);
      if (i == 254) begin
        checks++; if (drop_count !== 8'd254) $display("FAIL sat_254 got %0d expected 254", drop_count); else passed++;
      end
      if (i == 255) begin
        checks++; if (drop_count !== 8'd255) $display("FAIL sat_255 got %0d expected 255", drop_count); else passed++;
      end
    end
    checks++; if (drop_count !== 8'd255) $display("FAIL sat_hold got %0d expected 255", drop_count); else passed++;
    checks++; if (overflow !== 1'b1) $display("FAIL sat_overflow got %b expected 1", overflow); else passed++;
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    checks++; if (drop_count !== 8'd0 || overflow !== 1'b0) $display("FAIL sat_clear got dc=%0d ov=%b expected dc=0 ov=0", drop_count, overflow); else passed++;
    clr_stats = 1'b1;
    push(32'h5B000001, 1'b1);
    clr_stats = 1'b0;
    checks++; if (drop_count !== 8'd1 || overflow !== 1'b1) $display("FAIL sat_clr_vs_drop got dc=%0d ov=%b expected dc=1 ov=1", drop_count, overflow); else passed++;
    checks++; if (pkt_count !== 4'd1) $display("FAIL sat_pkt_count got %0d expected 1", pkt_count); else passed++;
    m_tready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    checks++; if (m_tvalid !== 1'b0 || pkt_count !== 4'd0) $display("FAIL sat_drain got v=%b pc=%0d expected v=0 pc=0", m_tvalid, pkt_count); else passed++;
  endtask

  task automatic test_reset_mid_packet();
    m_tready = 1'b0;
    push(32'h61000001, 1'b0);
    push(32'h61000002, 1'b1);
    push(32'h62000001, 1'b0);
    push(32'h62000002, 1'b1);
    push(32'h63000001, 1'b0);
    push(32'h63000002, 1'b0);
    checks++; if (pkt_count !== 4'd2) $display("FAIL rstmid_pre_pkts got %0d expected 2", pkt_count); else passed++;
    mrst = 1'b1;
    step();
    mrst = 1'b0;
    checks++; if (m_tvalid !== 1'b0) $display("FAIL rstmid_valid got %b expected 0", m_tvalid); else passed++;
    checks++; if (s_tready !== 1'b1) $display("FAIL rstmid_ready got %b expected 1", s_tready); else passed++;
    checks++; if (pkt_count !== 4'd0) $display("FAIL rstmid_pkts got %0d expected 0", pkt_count); else passed++;
    checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) $display("FAIL rstmid_stats got dc=%0d ov=%b expected dc=0 ov=0", drop_count, overflow); else passed++;
    m_tready = 1'b1;
    push(32'hF6000001, 1'b0);
    checks++; if (m_tvalid !== 1'b0) $display("FAIL rstmid_new_early got %b expected 0", m_tvalid); else passed++;
    push(32'hF6000002, 1'b1);
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== 32'hF6000001 || m_tlast !== 1'b0) $display("FAIL rstmid_new_w1 got v=%b d=%h l=%b expected v=1 d=F6000001 l=0", m_tvalid, m_tdata, m_tlast); else passed++;
    step();
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== 32'hF6000002 || m_tlast !== 1'b1) $display("FAIL rstmid_new_w2 got v=%b d=%h l=%b expected v=1 d=F6000002 l=1", m_tvalid, m_tdata, m_tlast); else passed++;
    step();
    checks++; if (m_tvalid !== 1'b0 || pkt_count !== 4'd0) $display("FAIL rstmid_new_done got v=%b pc=%0d expected v=0 pc=0", m_tvalid, pkt_count); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_until_commit();
    test_overflow_drop();
    test_long_packet();
    test_saturation();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
